// File: rtl/shift_reg_param.sv
// Parametrised universal shift register: parallel load, single-step shifts and
// counter-driven multi-step shifts in logical, arithmetic or rotate mode.
module shift_reg_param #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             shift,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  input  logic [CNT_W-1:0] amount,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ser_q, ser_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH:0]   live_step;
  logic [WIDTH:0]   run_step;

  // One shift step; result is {bit shifted out, new register value}.
  // Reserved mode 11 falls through to the logical fill.
  function automatic logic [WIDTH:0] shift_step(
    input logic [WIDTH-1:0] v,
    input logic             d,
    input logic [1:0]       m,
    input logic             si
  );
    logic fill;
    if (!d) begin
      if (m == MODE_ARITH)    fill = v[WIDTH-1];
      else if (m == MODE_ROT) fill = v[0];
      else                    fill = si;
      shift_step = {v[0], fill, v[WIDTH-1:1]};
    end else begin
      if (m == MODE_ARITH)    fill = 1'b0;
      else if (m == MODE_ROT) fill = v[WIDTH-1];
      else                    fill = si;
      shift_step = {v[WIDTH-1], v[WIDTH-2:0], fill};
    end
  endfunction

  assign live_step = shift_step(out_q, dir, mode, ser_in);
  assign run_step  = shift_step(out_q, dir_q, mode_q, ser_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      ser_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  // Priority: load > start (idle) > running step > single shift (idle) > hold.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ser_d   = ser_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    if (load) begin
      out_d = in;
      if (state_q == RUN) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else if (start && (state_q == IDLE)) begin
      if (amount == '0) begin
        done_d = 1'b1;
      end else begin
        state_d = RUN;
        cnt_d   = amount;
        dir_d   = dir;
        mode_d  = mode;
      end
    end else if (state_q == RUN) begin
      {ser_d, out_d} = run_step;
      cnt_d          = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (shift) begin
      {ser_d, out_d} = live_step;
    end
  end

  assign out     = out_q;
  assign ser_out = ser_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_shift_reg_param.sv
// Scoreboard bench for shift_reg_param: a behavioural model queues the expected
// outputs for every clock and each scenario task compares them with the DUT.
module tb_shift_reg_param;

  localparam int unsigned W  = 9;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [W-1:0] out;
    logic         ser;
    logic         busy;
    logic         done;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset, load, shift, dir, ser_in, start;
  logic [W-1:0]  in;
  logic [1:0]    mode;
  logic [CW-1:0] amount;
  logic [W-1:0]  out;
  logic          ser_out, busy, done;

  int tests = 0;
  int fails = 0;

  obs_t exp_q[$];
  obs_t obs_q[$];

  // reference model state
  logic [W-1:0]  m_out;
  logic          m_ser, m_busy, m_done, m_dir;
  logic [1:0]    m_mode;
  int            m_cnt;

  shift_reg_param #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .shift(shift), .dir(dir),
    .mode(mode), .ser_in(ser_in), .amount(amount), .start(start),
    .out(out), .ser_out(ser_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Returns {bit leaving the register, new value}.
  function automatic logic [W:0] model_step(logic [W-1:0] v, logic d, logic [1:0] m, logic si);
    logic [W-1:0] r;
    logic         b;
    if (d == 1'b0) begin
      b = v[0];
      r = v >> 1;
      case (m)
        2'b01:   r[W-1] = v[W-1];
        2'b10:   r[W-1] = v[0];
        default: r[W-1] = si;
      endcase
    end else begin
      b = v[W-1];
      r = v << 1;
      case (m)
        2'b01:   r[0] = 1'b0;
        2'b10:   r[0] = v[W-1];
        default: r[0] = si;
      endcase
    end
    return {b, r};
  endfunction

  // Advance model with current inputs, queue expectation, clock, capture DUT.
  task automatic tick();
    obs_t e;
    logic [W:0] s;
    m_done = 1'b0;
    if (reset) begin
      m_out = '0; m_ser = 1'b0; m_busy = 1'b0; m_cnt = 0;
    end else if (load) begin
      m_out = in;
      if (m_busy) begin m_busy = 1'b0; m_cnt = 0; end
    end else if (start && !m_busy) begin
      if (amount == 0) m_done = 1'b1;
      else begin m_busy = 1'b1; m_cnt = int'(amount); m_dir = dir; m_mode = mode; end
    end else if (m_busy) begin
      s = model_step(m_out, m_dir, m_mode, ser_in);
      {m_ser, m_out} = s;
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin m_busy = 1'b0; m_done = 1'b1; end
    end else if (shift) begin
      s = model_step(m_out, dir, mode, ser_in);
      {m_ser, m_out} = s;
    end
    e = '{out: m_out, ser: m_ser, busy: m_busy, done: m_done};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs_q.push_back('{out: out, ser: ser_out, busy: busy, done: done});
  endtask

  task automatic idle_inputs();
    reset = 1'b0; load = 1'b0; shift = 1'b0; start = 1'b0;
    dir = 1'b0; mode = 2'b00; ser_in = 1'b0; amount = '0; in = '0;
  endtask

  task automatic do_load(logic [W-1:0] v);
    idle_inputs(); load = 1'b1; in = v; tick(); load = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e, o;
    idle_inputs();
    reset = 1'b1; load = 1'b1; in = 9'h1FF; start = 1'b1; amount = 4'd3;
    tick(); tick();
    idle_inputs();
    tests++;
    if (out !== '0 || ser_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: out=%h ser=%b busy=%b done=%b, want all zero", out, ser_out, busy, done);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset_sb: got out=%h ser=%b busy=%b done=%b, want out=%h ser=%b busy=%b done=%b",
                 o.out, o.ser, o.busy, o.done, e.out, e.ser, e.busy, e.done);
      end
    end
  endtask

  task automatic test_single_step();
    obs_t e, o;
    do_load(9'h1A5);
    shift = 1'b1; dir = 1'b0; mode = 2'b00; ser_in = 1'b1;
    tick();
    shift = 1'b0;
    tests++;
    if (out !== 9'h1D2 || ser_out !== 1'b1) begin
      fails++;
      $display("FAIL single_right: out=%h ser=%b, want out=1d2 ser=1", out, ser_out);
    end
    for (int i = 0; i < 24; i++) begin
      shift = 1'b1; dir = i[0]; mode = 2'(i >> 1); ser_in = i[2] ^ i[4];
      tick();
    end
    idle_inputs();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL single_sb: got out=%h ser=%b busy=%b done=%b, want out=%h ser=%b busy=%b done=%b",
                 o.out, o.ser, o.busy, o.done, e.out, e.ser, e.busy, e.done);
      end
    end
  endtask

  task automatic test_rotate_multi();
    obs_t e, o;
    int nbusy = 0, ndone = 0;
    logic [W-1:0] at_done = '0;
    logic ser_at_done = 1'b1, busy_at_done = 1'b1;
    do_load(9'h1A5);
    start = 1'b1; amount = 4'd3; dir = 1'b1; mode = 2'b10;
    tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy) nbusy++;
      if (done) begin ndone++; at_done = out; ser_at_done = ser_out; busy_at_done = busy; end
    end
    tests++;
    if (nbusy != 2 || ndone != 1 || at_done !== 9'h12E || ser_at_done !== 1'b0 || busy_at_done !== 1'b0) begin
      fails++;
      $display("FAIL rotl3: busy_after_start=%0d done_pulses=%0d out=%h ser=%b busy=%b, want 2 1 12e 0 0",
               nbusy, ndone, at_done, ser_at_done, busy_at_done);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL rotl3_sb: got out=%h ser=%b busy=%b done=%b, want out=%h ser=%b busy=%b done=%b",
                 o.out, o.ser, o.busy, o.done, e.out, e.ser, e.busy, e.done);
      end
    end
  endtask

  task automatic test_arith_multi();
    obs_t e, o;
    int done_cyc = -1;
    do_load(9'h1A5);
    start = 1'b1; amount = 4'd4; dir = 1'b0; mode = 2'b01;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      dir = ~dir; mode = mode + 2'd1; ser_in = ~ser_in;
      tick();
      if (done && done_cyc < 0) done_cyc = i;
      if (i == 4) begin
        tests++;
        if (out !== 9'h1FA || ser_out !== 1'b0) begin
          fails++;
          $display("FAIL asr4: out=%h ser=%b, want out=1fa ser=0", out, ser_out);
        end
      end
    end
    idle_inputs();
    tests++;
    if (done_cyc != 4) begin
      fails++;
      $display("FAIL asr4_latency: done after %0d edges, want 4", done_cyc);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL asr4_sb: got out=%h ser=%b busy=%b done=%b, want out=%h ser=%b busy=%b done=%b",
                 o.out, o.ser, o.busy, o.done, e.out, e.ser, e.busy, e.done);
      end
    end
  endtask

  task automatic test_zero_amount();
    obs_t e, o;
    do_load(9'h0F0);
    start = 1'b1; amount = '0; dir = 1'b1; mode = 2'b10;
    tick();
    idle_inputs();
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || out !== 9'h0F0) begin
      fails++;
      $display("FAIL zero_amt: done=%b busy=%b out=%h, want done=1 busy=0 out=0f0", done, busy, out);
    end
    tick(); tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL zero_sb: got out=%h ser=%b busy=%b done=%b, want out=%h ser=%b busy=%b done=%b",
                 o.out, o.ser, o.busy, o.done, e.out, e.ser, e.busy, e.done);
      end
    end
  endtask

  task automatic test_abort_and_ignored();
    obs_t e, o;
    int ndone = 0;
    do_load(9'h0C3);
    start = 1'b1; amount = 4'd5; dir = 1'b0; mode = 2'b00;
    tick();
    start = 1'b0;
    tick();
    load = 1'b1; in = 9'h155;
    tick();
    load = 1'b0;
    tests++;
    if (out !== 9'h155 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort: out=%h busy=%b done=%b, want out=155 busy=0 done=0", out, busy, done);
    end
    for (int i = 0; i < 4; i++) begin tick(); if (done) ndone++; end
    tests++;
    if (ndone != 0) begin
      fails++;
      $display("FAIL abort_done: %0d done pulses after abort, want 0", ndone);
    end
    start = 1'b1; amount = 4'd3; dir = 1'b1; mode = 2'b00; ser_in = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; amount = 4'd9; shift = 1'b1; dir = 1'b0; mode = 2'b10;
      tick();
    end
    idle_inputs();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL abort_sb: got out=%h ser=%b busy=%b done=%b, want out=%h ser=%b busy=%b done=%b",
                 o.out, o.ser, o.busy, o.done, e.out, e.ser, e.busy, e.done);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    obs_t e, o;
    do_load(9'h1A5);
    start = 1'b1; amount = 4'd7; dir = 1'b1; mode = 2'b00; ser_in = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (out !== '0 || busy !== 1'b0 || done !== 1'b0 || ser_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: out=%h busy=%b done=%b ser=%b, want all zero", out, busy, done, ser_out);
    end
    do_load(9'h081);
    start = 1'b1; amount = 4'd2; dir = 1'b0; mode = 2'b10;
    tick();
    idle_inputs();
    tick(); tick();
    tests++;
    if (out !== 9'h0A0 || done !== 1'b1 || ser_out !== 1'b0) begin
      fails++;
      $display("FAIL restart: out=%h done=%b ser=%b, want out=0a0 done=1 ser=0", out, done, ser_out);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL rstmid_sb: got out=%h ser=%b busy=%b done=%b, want out=%h ser=%b busy=%b done=%b",
                 o.out, o.ser, o.busy, o.done, e.out, e.ser, e.busy, e.done);
      end
    end
  endtask

  task automatic test_long_amounts();
    obs_t e, o;
    do_load(9'h13B);
    start = 1'b1; amount = 4'd9; dir = 1'b1; mode = 2'b10;
    tick();
    idle_inputs();
    repeat (9) tick();
    tests++;
    if (out !== 9'h13B || done !== 1'b1) begin
      fails++;
      $display("FAIL rot_width: out=%h done=%b, want out=13b done=1", out, done);
    end
    start = 1'b1; amount = 4'd15; dir = 1'b0; mode = 2'b00; ser_in = 1'b0;
    tick();
    idle_inputs();
    repeat (15) tick();
    tests++;
    if (out !== '0 || done !== 1'b1) begin
      fails++;
      $display("FAIL fill_zero: out=%h done=%b, want out=000 done=1", out, done);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL long_sb: got out=%h ser=%b busy=%b done=%b, want out=%h ser=%b busy=%b done=%b",
                 o.out, o.ser, o.busy, o.done, e.out, e.ser, e.busy, e.done);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 99) == 0);
      load   = ($urandom_range(0, 9) == 0);
      start  = ($urandom_range(0, 5) == 0);
      shift  = $urandom_range(0, 1) == 1;
      dir    = $urandom_range(0, 1) == 1;
      mode   = 2'($urandom_range(0, 3));
      ser_in = $urandom_range(0, 1) == 1;
      amount = CW'($urandom_range(0, 15));
      in     = W'($urandom);
      tick();
    end
    idle_inputs();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL random_sb: got out=%h ser=%b busy=%b done=%b, want out=%h ser=%b busy=%b done=%b",
                 o.out, o.ser, o.busy, o.done, e.out, e.ser, e.busy, e.done);
      end
    end
  endtask

  initial begin
    m_out = '0; m_ser = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    m_dir = 1'b0; m_mode = 2'b00; m_cnt = 0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_step();
    test_rotate_multi();
    test_arith_multi();
    test_zero_amount();
    test_abort_and_ignored();
    test_reset_mid_op();
    test_long_amounts();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
